// File: rtl/stim_replay_seq_if.sv
// Stimulus replay bus: the loader write port into the sequencer's entry memory
// and the replayed stimulus stream that the sequencer drives toward the DUT.
//   wr_en/wr_addr/wr_data : entry write port (wr_data[DATA_W] = observe flag)
//   stim_data/stim_obs    : current payload and its gated observe flag
//   stim_valid            : a fresh entry is on the bus this cycle
//   pc                    : index of the entry on stim_data
// master = sequencer side, slave = host/bench side.
interface stim_replay_seq_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W:0]   wr_data;
  logic [DATA_W-1:0] stim_data;
  logic              stim_obs;
  logic              stim_valid;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  wr_en, wr_addr, wr_data,
    output stim_data, stim_obs, stim_valid, pc
  );

  modport slave (
    output wr_en, wr_addr, wr_data,
    input  stim_data, stim_obs, stim_valid, pc
  );
endinterface

// File: rtl/stim_replay_seq.sv
// Stimulus replay sequencer. Holds DEPTH entries of {observe flag, payload},
// loaded through the interface write port while not running, and replays the
// first len entries one per cycle onto the stimulus bus, once or continuously.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus        : stim_replay_seq_if.master (write port + stimulus stream)
//   len        : entries per pass, sampled on an accepted start
//   loop_mode  : sampled on an accepted start, 1 = wrap continuously
//   start      : begin replay from IDLE or DONE
//   pause      : hold pointer and outputs while running
//   abort      : return to IDLE, highest priority
//   busy/done  : state is RUN / DONE
//   pass_cnt   : completed passes since start, saturating
module stim_replay_seq #(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 36,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int LOOP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  stim_replay_seq_if.master     bus,
  input  logic [ADDR_W:0]       len,
  input  logic                  loop_mode,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LOOP_CNT_W-1:0] pass_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t state, state_next;

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len_r;
  logic              loop_r;
  // Set when the final entry of a single pass has been issued; the following
  // cycle is spent in RUN with nothing issued so that done rises exactly as
  // stim_valid falls.
  logic              drain;

  logic [DATA_W-1:0] data_p1;
  logic              obs_p1;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;

  logic start_ok;
  logic issue;
  logic last;
  logic wr_ok;

  function automatic logic [LOOP_CNT_W-1:0] sat_inc(input logic [LOOP_CNT_W-1:0] v);
    if (&v) return v;
    return v + LOOP_CNT_W'(1);
  endfunction

  assign start_ok = start && (len != '0) && (len <= DEPTH_L);
  assign last     = ({1'b0, ptr} == (len_r - ONE_L));
  assign wr_ok    = bus.wr_en && (state != RUN) && ({1'b0, bus.wr_addr} < DEPTH_L);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_ok) state_next = RUN;
        RUN: begin
          if (drain)       state_next = DONE;
          else if (!pause) issue = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Entry memory is not reset; a write issued together with start lands
  // before the first read, which happens one edge later.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end

  // ---- stage p1: memory read registered onto the stimulus bus ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      len_r    <= '0;
      loop_r   <= 1'b0;
      drain    <= 1'b0;
      pass_cnt <= '0;
      data_p1  <= '0;
      obs_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
    end else begin
      if (!issue) begin
        vld_p1 <= 1'b0;
        obs_p1 <= 1'b0;
      end
      if (!abort && (state != RUN) && start_ok) begin
        len_r    <= len;
        loop_r   <= loop_mode;
        ptr      <= '0;
        pass_cnt <= '0;
        drain    <= 1'b0;
      end
      if (issue) begin
        data_p1 <= mem[ptr][DATA_W-1:0];
        obs_p1  <= mem[ptr][DATA_W];
        vld_p1  <= 1'b1;
        pc_p1   <= ptr;
        if (last) begin
          ptr      <= '0;
          pass_cnt <= sat_inc(pass_cnt);
          drain    <= !loop_r;
        end else begin
          ptr <= ptr + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.stim_data  = data_p1;
  assign bus.stim_obs   = obs_p1;
  assign bus.stim_valid = vld_p1;
  assign bus.pc         = pc_p1;
  assign busy           = (state == RUN);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_stim_replay_seq.sv
// Bench for stim_replay_seq: a DEPTH=36/DATA_W=128 instance for the replay
// features and a DEPTH=2/DATA_W=8 instance with a narrow pass counter for
// saturation. Expected streams come from an array copy of the loaded entries.
module tb_stim_replay_seq;
  localparam int DW     = 128;
  localparam int DEPTH  = 36;
  localparam int AW     = $clog2(DEPTH);
  localparam int LCW    = 16;
  localparam int SDW    = 8;
  localparam int SDEPTH = 2;
  localparam int SAW    = 1;
  localparam int SLCW   = 12;

  logic clk = 1'b0;
  logic rst;

  logic [AW:0]      len;
  logic             loop_mode, start, pause, abort;
  logic             busy, done;
  logic [LCW-1:0]   pass_cnt;

  logic [SAW:0]     s_len;
  logic             s_loop_mode, s_start, s_pause, s_abort;
  logic             s_busy, s_done;
  logic [SLCW-1:0]  s_pass_cnt;

  stim_replay_seq_if #(.DATA_W(DW),  .ADDR_W(AW))  bus();
  stim_replay_seq_if #(.DATA_W(SDW), .ADDR_W(SAW)) s_bus();

  stim_replay_seq #(.DATA_W(DW), .DEPTH(DEPTH), .LOOP_CNT_W(LCW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .len(len), .loop_mode(loop_mode),
    .start(start), .pause(pause), .abort(abort), .busy(busy), .done(done),
    .pass_cnt(pass_cnt)
  );

  stim_replay_seq #(.DATA_W(SDW), .DEPTH(SDEPTH), .LOOP_CNT_W(SLCW)) s_dut (
    .clk(clk), .rst(rst), .bus(s_bus), .len(s_len), .loop_mode(s_loop_mode),
    .start(s_start), .pause(s_pause), .abort(s_abort), .busy(s_busy), .done(s_done),
    .pass_cnt(s_pass_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW:0]  mem_m   [DEPTH];
  logic [SDW:0] s_mem_m [SDEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW:0] rnd_entry();
    return {1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load(input int addr, input logic [DW:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    mem_m[addr] = d;
  endtask

  // Entries 0..3 = {obs = k[0], payload = 0xA0 + k}
  task automatic load_pattern();
    for (int k = 0; k < 4; k++) load(k, {1'(k & 1), 120'd0, 8'(8'hA0 + k)});
  endtask

  task automatic go(input int l, input logic lp);
    len       = (AW+1)'(l);
    loop_mode = lp;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.stim_valid !== 1'b0 || bus.stim_obs !== 1'b0 || bus.stim_data !== '0 ||
        bus.pc !== '0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== '0) begin
      bad++;
      $display("FAIL reset: valid=%b obs=%b data=%h pc=%0d busy=%b done=%b pass=%0d, want all zero",
               bus.stim_valid, bus.stim_obs, bus.stim_data, bus.pc, busy, done, pass_cnt);
    end
  endtask

  task automatic test_single_pass();
    for (int rep = 0; rep < 3; rep++) begin
      int l;
      logic [DW:0] e;
      if (rep == 0) begin
        load_pattern();
        l = 4;
      end else begin
        for (int a = 0; a < DEPTH; a++) load(a, rnd_entry());
        l = (rep == 1) ? DEPTH : $urandom_range(1, DEPTH - 1);
      end
      go(l, 1'b0);
      for (int i = 0; i < l; i++) begin
        tick();
        e = mem_m[i];
        total++;
        if (bus.stim_valid !== 1'b1 || bus.stim_data !== e[DW-1:0] || bus.stim_obs !== e[DW] ||
            bus.pc !== AW'(i) || busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL single_pass rep=%0d i=%0d: valid=%b data=%h obs=%b pc=%0d busy=%b done=%b, want valid=1 data=%h obs=%b pc=%0d busy=1 done=0",
                   rep, i, bus.stim_valid, bus.stim_data, bus.stim_obs, bus.pc, busy, done,
                   e[DW-1:0], e[DW], i);
        end
      end
      tick();
      e = mem_m[l-1];
      total++;
      if (bus.stim_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || pass_cnt !== LCW'(1) ||
          bus.stim_data !== e[DW-1:0] || bus.stim_obs !== 1'b0) begin
        bad++;
        $display("FAIL single_pass_end rep=%0d: valid=%b done=%b busy=%b pass=%0d data=%h, want valid=0 done=1 busy=0 pass=1 data=%h",
                 rep, bus.stim_valid, done, busy, pass_cnt, bus.stim_data, e[DW-1:0]);
      end
    end
  endtask

  task automatic test_loop();
    for (int rep = 0; rep < 2; rep++) begin
      int l, n;
      logic [DW:0] e;
      if (rep == 0) begin
        load_pattern();
        l = 4;
        n = 10;
      end else begin
        l = $urandom_range(1, DEPTH);
        n = 3 * l + $urandom_range(0, l);
      end
      go(l, 1'b1);
      for (int i = 0; i < n; i++) begin
        tick();
        e = mem_m[i % l];
        total++;
        if (bus.stim_valid !== 1'b1 || bus.stim_data !== e[DW-1:0] || bus.stim_obs !== e[DW] ||
            bus.pc !== AW'(i % l) || busy !== 1'b1 || pass_cnt !== LCW'((i + 1) / l)) begin
          bad++;
          $display("FAIL loop rep=%0d i=%0d: valid=%b data=%h pc=%0d busy=%b pass=%0d, want valid=1 data=%h pc=%0d busy=1 pass=%0d",
                   rep, i, bus.stim_valid, bus.stim_data, bus.pc, busy, pass_cnt,
                   e[DW-1:0], i % l, (i + 1) / l);
        end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || bus.stim_valid !== 1'b0 || pass_cnt !== LCW'(n / l)) begin
        bad++;
        $display("FAIL loop_abort rep=%0d: busy=%b done=%b valid=%b pass=%0d, want 0 0 0 pass=%0d",
                 rep, busy, done, bus.stim_valid, pass_cnt, n / l);
      end
    end
  endtask

  task automatic test_pause();
    int l, idx, cyc;
    logic p;
    logic [DW:0] e;
    // Directed: pause for three cycles after A1 is issued.
    load_pattern();
    go(4, 1'b0);
    tick();
    tick();
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.stim_valid !== 1'b0 || bus.stim_obs !== 1'b0 || bus.stim_data !== DW'(8'hA1) ||
          bus.pc !== AW'(1) || busy !== 1'b1) begin
        bad++;
        $display("FAIL pause_hold k=%0d: valid=%b obs=%b data=%h pc=%0d busy=%b, want valid=0 obs=0 data=a1 pc=1 busy=1",
                 k, bus.stim_valid, bus.stim_obs, bus.stim_data, bus.pc, busy);
      end
    end
    pause = 1'b0;
    for (int k = 2; k < 4; k++) begin
      tick();
      total++;
      if (bus.stim_valid !== 1'b1 || bus.stim_data !== DW'(8'hA0 + k) || bus.pc !== AW'(k)) begin
        bad++;
        $display("FAIL pause_resume k=%0d: valid=%b data=%h pc=%0d, want valid=1 data=%h pc=%0d",
                 k, bus.stim_valid, bus.stim_data, bus.pc, 8'hA0 + k, k);
      end
    end
    tick();
    total++;
    if (done !== 1'b1 || bus.stim_valid !== 1'b0) begin
      bad++;
      $display("FAIL pause_done: done=%b valid=%b, want done=1 valid=0", done, bus.stim_valid);
    end
    // Randomised pause pattern over a single pass.
    l = $urandom_range(4, DEPTH);
    go(l, 1'b0);
    idx = 0;
    cyc = 0;
    while (idx < l && cyc < 20 * l + 50) begin
      p = ($urandom_range(0, 2) == 0);
      pause = p;
      tick();
      cyc++;
      total++;
      if (!p) begin
        e = mem_m[idx];
        if (bus.stim_valid !== 1'b1 || bus.stim_data !== e[DW-1:0] || bus.stim_obs !== e[DW] ||
            bus.pc !== AW'(idx)) begin
          bad++;
          $display("FAIL pause_rand issue idx=%0d: valid=%b data=%h pc=%0d, want valid=1 data=%h pc=%0d",
                   idx, bus.stim_valid, bus.stim_data, bus.pc, e[DW-1:0], idx);
        end
        idx++;
      end else begin
        e = (idx > 0) ? mem_m[idx-1] : '0;
        if (bus.stim_valid !== 1'b0 || bus.stim_obs !== 1'b0 || busy !== 1'b1 ||
            (idx > 0 && (bus.stim_data !== e[DW-1:0] || bus.pc !== AW'(idx - 1)))) begin
          bad++;
          $display("FAIL pause_rand hold idx=%0d: valid=%b obs=%b busy=%b data=%h, want valid=0 obs=0 busy=1",
                   idx, bus.stim_valid, bus.stim_obs, busy, bus.stim_data);
        end
      end
    end
    pause = 1'b0;
    total++;
    if (idx != l) begin
      bad++;
      $display("FAIL pause_rand timeout: issued=%0d, want %0d", idx, l);
    end
    tick();
    total++;
    if (done !== 1'b1 || bus.stim_valid !== 1'b0 || pass_cnt !== LCW'(1)) begin
      bad++;
      $display("FAIL pause_rand_done: done=%b valid=%b pass=%0d, want 1 0 1", done, bus.stim_valid, pass_cnt);
    end
  endtask

  task automatic test_abort();
    load_pattern();
    go(4, 1'b0);
    tick();
    tick();
    // Write while running must be dropped.
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = {1'b0, 120'd0, 8'hFF};
    tick();
    bus.wr_en = 1'b0;
    total++;
    if (bus.stim_valid !== 1'b1 || bus.stim_data !== DW'(8'hA2) || bus.pc !== AW'(2)) begin
      bad++;
      $display("FAIL abort_pre: valid=%b data=%h pc=%0d, want valid=1 data=a2 pc=2",
               bus.stim_valid, bus.stim_data, bus.pc);
    end
    abort = 1'b1;
    pause = 1'b1;
    tick();
    abort = 1'b0;
    pause = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.stim_valid !== 1'b0 || bus.stim_obs !== 1'b0 ||
        bus.stim_data !== DW'(8'hA2) || bus.pc !== AW'(2) || pass_cnt !== '0) begin
      bad++;
      $display("FAIL abort: busy=%b done=%b valid=%b obs=%b data=%h pc=%0d pass=%0d, want 0 0 0 0 a2 2 0",
               busy, done, bus.stim_valid, bus.stim_obs, bus.stim_data, bus.pc, pass_cnt);
    end
    go(4, 1'b0);
    tick();
    total++;
    if (bus.stim_valid !== 1'b1 || bus.stim_data !== DW'(8'hA0)) begin
      bad++;
      $display("FAIL abort_restart: valid=%b data=%h, want valid=1 data=a0", bus.stim_valid, bus.stim_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_bad_len();
    int bl [2];
    bl[0] = 0;
    bl[1] = DEPTH + 1;
    for (int k = 0; k < 2; k++) begin
      go(bl[k], 1'b0);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL bad_len len=%0d: busy=%b done=%b, want 0 0", bl[k], busy, done);
      end
      tick();
      total++;
      if (bus.stim_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL bad_len_valid len=%0d: valid=%b busy=%b, want 0 0", bl[k], bus.stim_valid, busy);
      end
    end
  endtask

  task automatic test_write_with_start();
    logic [DW:0] e;
    e = rnd_entry();
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = e;
    len         = (AW+1)'(1);
    loop_mode   = 1'b0;
    start       = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    start     = 1'b0;
    mem_m[0]  = e;
    tick();
    total++;
    if (bus.stim_valid !== 1'b1 || bus.stim_data !== e[DW-1:0] || bus.stim_obs !== e[DW]) begin
      bad++;
      $display("FAIL write_with_start: valid=%b data=%h obs=%b, want valid=1 data=%h obs=%b",
               bus.stim_valid, bus.stim_data, bus.stim_obs, e[DW-1:0], e[DW]);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [DW:0] e;
    go(4, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_reset();
    // Memory survives reset.
    go(1, 1'b0);
    tick();
    e = mem_m[0];
    total++;
    if (bus.stim_valid !== 1'b1 || bus.stim_data !== e[DW-1:0]) begin
      bad++;
      $display("FAIL post_reset_replay: valid=%b data=%h, want valid=1 data=%h",
               bus.stim_valid, bus.stim_data, e[DW-1:0]);
    end
    tick();
  endtask

  task automatic test_saturate();
    int errs = 0;
    int first_i = -1;
    int n = 2 * ((1 << SLCW) + 4);
    int ep;
    logic [SDW:0] e;
    for (int a = 0; a < SDEPTH; a++) begin
      e = {1'($urandom_range(0, 1)), 8'($urandom)};
      s_bus.wr_en   = 1'b1;
      s_bus.wr_addr = SAW'(a);
      s_bus.wr_data = e;
      tick();
      s_mem_m[a] = e;
    end
    s_bus.wr_en = 1'b0;
    s_len       = 2'd2;
    s_loop_mode = 1'b1;
    s_start     = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      e  = s_mem_m[i % 2];
      ep = ((i + 1) / 2 > (1 << SLCW) - 1) ? (1 << SLCW) - 1 : (i + 1) / 2;
      if (s_bus.stim_valid !== 1'b1 || s_bus.stim_data !== e[SDW-1:0] ||
          s_pass_cnt !== SLCW'(ep)) begin
        errs++;
        if (first_i < 0) first_i = i;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL saturate_stream: %0d bad cycles, first at i=%0d, want 0", errs, first_i);
    end
    total++;
    if (s_pass_cnt !== {SLCW{1'b1}} || s_busy !== 1'b1) begin
      bad++;
      $display("FAIL saturate_final: pass=%h busy=%b, want pass=%h busy=1", s_pass_cnt, s_busy, {SLCW{1'b1}});
    end
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    len         = '0;
    loop_mode   = 1'b0;
    start       = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    s_len       = '0;
    s_loop_mode = 1'b0;
    s_start     = 1'b0;
    s_pause     = 1'b0;
    s_abort     = 1'b0;
    s_bus.wr_en   = 1'b0;
    s_bus.wr_addr = '0;
    s_bus.wr_data = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_reset();
    test_single_pass();
    test_loop();
    test_pause();
    test_abort();
    test_bad_len();
    test_write_with_start();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
